stim_sweep: RTL and testbench

- Parametrised, self-checking stimulus sequencer for small gate-level combinational circuits.
- Walks all 2^N_IN input combinations and holds each for a programmable number of cycles.
- Samples the circuit's 1-bit response at the end of each hold and compares it against a truth-table parameter.
- Reports mismatch count, first failing vector and completion. Synthesisable successor to hand-written fixed-delay stimulus blocks; instantiated beside the circuit under test.

---
 rtl/stim_sweep_pkg.sv | 19 +
 rtl/stim_sweep_hold_timer.sv | 30 +++
 rtl/stim_sweep.sv | 158 +++++++++++++++
 tb/tb_stim_sweep.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/stim_sweep_pkg.sv
// Shared types and helpers for the stim_sweep stimulus sequencer.
package sweep_pkg;

    // Largest supported number of driven circuit inputs.
    localparam int MAX_N_IN = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    // Binary-reflected Gray code of i.
    function automatic logic [MAX_N_IN:0] gray_of(input logic [MAX_N_IN:0] i);
        return i ^ (i >> 1);
    endfunction

endpackage

// File: rtl/stim_sweep_hold_timer.sv
// Loadable down-counter with a zero flag; times how long each vector is held.
module sweep_hold_timer
    import sweep_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority; decrement stops at zero so the flag stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/stim_sweep.sv
// stim_sweep: walks every input vector of a small combinational circuit,
// holds each for HOLD cycles, samples the 1-bit response and checks it
// against TRUTH. Optional macro STIM_SWEEP_GRAY_EN selects Gray-order
// vectors instead of binary order.
module stim_sweep
    import sweep_pkg::*;
#(
    parameter int                    N_IN  = 3,
    parameter int                    HOLD  = 20,
    parameter logic [(1<<N_IN)-1:0]  TRUTH = 8'hE8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            resp,
    output logic            sample,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   fail_cnt,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_vld
);

    if (HOLD < 1 || N_IN < 1 || N_IN > MAX_N_IN) begin : g_param_err
        $error("stim_sweep: HOLD must be >= 1 and N_IN within 1..8");
    end

    localparam int            CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] HOLD_M1  = CW'(HOLD - 1);
    localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'((1 << N_IN) - 1);

    sweep_state_t    r_state, w_state_nxt;
    logic [N_IN:0]   r_idx;
    logic [N_IN-1:0] r_stim;
    logic            r_sample, r_busy, r_done;
    logic [N_IN:0]   r_fail_cnt;
    logic [N_IN-1:0] r_ffv;
    logic            r_ffvld;

    logic            w_load, w_dec, w_zero;
    logic            w_last, w_mis;
    logic [N_IN:0]   w_idx_inc;
    logic [N_IN-1:0] w_map_nxt;

    assign w_last    = (r_idx == LAST_IDX);
    assign w_mis     = (resp != TRUTH[r_stim]);
    assign w_idx_inc = r_idx + (N_IN+1)'(1);

`ifdef STIM_SWEEP_GRAY_EN
    logic [MAX_N_IN:0] w_gray_in;
    // Widen the next index to the package helper's width.
    always_comb begin
        w_gray_in         = '0;
        w_gray_in[N_IN:0] = w_idx_inc;
    end
    assign w_map_nxt = N_IN'(gray_of(w_gray_in));
`else
    assign w_map_nxt = N_IN'(w_idx_inc);
`endif

    sweep_hold_timer #(.W(CW)) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (HOLD_M1),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and hold-timer control.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = DRIVE;
                    w_load      = 1'b1;
                end
            end
            DRIVE: begin
                if (w_zero) w_state_nxt = SAMPLE;
                else        w_dec       = 1'b1;
            end
            SAMPLE: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DRIVE;
                    w_load      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered outputs, vector index and result bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_stim     <= '0;
            r_sample   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fail_cnt <= '0;
            r_ffv      <= '0;
            r_ffvld    <= 1'b0;
        end else begin
            r_sample <= (w_state_nxt == SAMPLE);
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_fail_cnt <= '0;
                        r_ffvld    <= 1'b0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_idx      <= '0;
                        r_stim     <= '0;   // map(0) is 0 in both orders
                    end
                end
                SAMPLE: begin
                    if (w_mis) begin
                        r_fail_cnt <= r_fail_cnt + (N_IN+1)'(1);
                        if (!r_ffvld) begin
                            r_ffv   <= r_stim;
                            r_ffvld <= 1'b1;
                        end
                    end
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_idx  <= w_idx_inc;
                        r_stim <= w_map_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stim           = r_stim;
    assign sample         = r_sample;
    assign busy           = r_busy;
    assign done           = r_done;
    assign fail_cnt       = r_fail_cnt;
    assign first_fail_vec = r_ffv;
    assign first_fail_vld = r_ffvld;

endmodule

// File: tb/tb_stim_sweep.sv
// Scoreboard bench for stim_sweep (N_IN=3, HOLD=4, majority truth table).
module tb_stim_sweep;

    localparam int         N_IN  = 3;
    localparam int         HOLD  = 4;
    localparam int         NV    = 1 << N_IN;
    localparam logic [7:0] TRUTH = 8'hE8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            resp;
    logic [N_IN-1:0] stim;
    logic            sample, busy, done;
    logic [N_IN:0]   fail_cnt;
    logic [N_IN-1:0] first_fail_vec;
    logic            first_fail_vld;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;   // 0: majority gate, 1: output stuck at 0

    typedef struct {
        logic [N_IN-1:0] stim;
        int              cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    stim_sweep #(.N_IN(N_IN), .HOLD(HOLD), .TRUTH(TRUTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stim           (stim),
        .resp           (resp),
        .sample         (sample),
        .busy           (busy),
        .done           (done),
        .fail_cnt       (fail_cnt),
        .first_fail_vec (first_fail_vec),
        .first_fail_vld (first_fail_vld)
    );

    function automatic logic maj(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    function automatic logic model(input logic [2:0] v);
        return (mode == 1) ? 1'b0 : maj(v);
    endfunction

    assign resp = model(stim);

    // Expected k-th vector of a sweep.
    function automatic logic [2:0] order(input int k);
        logic [2:0] b;
        b = 3'(k);
`ifdef STIM_SWEEP_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sweep: start pulse, scoreboard of sampled vectors, final results.
    // inject: extra start pulses while vectors 2 and 6 are driven.
    // abort_vec >= 0: assert reset during that vector's DRIVE phase.
    task automatic run_sweep(input bit inject, input int abort_vec, input bit from_done);
        int              cyc;
        int              exp_fail;
        logic [N_IN-1:0] exp_ffv;
        bit              exp_vld;
        bit              p2, p6;
        logic [7:0]      tt;
        exp_t            e;
        tt = TRUTH;
        exp_fail = 0; exp_ffv = '0; exp_vld = 0; p2 = 0; p6 = 0;
        sb.delete();
        for (int k = 0; k < NV; k++) begin
            e.stim = order(k);
            e.cyc  = (k + 1) * (HOLD + 1);
            sb.push_back(e);
            if (model(e.stim) != tt[e.stim]) begin
                exp_fail++;
                if (!exp_vld) begin exp_vld = 1; exp_ffv = e.stim; end
            end
        end

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        if (from_done) begin
            chk("restart_done_low", 32'(done), 0);
            chk("restart_cnt_clr", 32'(fail_cnt), 0);
            chk("restart_vld_clr", 32'(first_fail_vld), 0);
        end
        chk("busy_after_start", 32'(busy), 1);

        while (!done && cyc < 200) begin
            start = 1'b0;
            if (abort_vec >= 0 && busy && !sample && stim == 3'(abort_vec)) begin
                rst_n = 1'b0;
                #1;
                chk("rst_stim", 32'(stim), 0);
                chk("rst_sample", 32'(sample), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_fail_cnt", 32'(fail_cnt), 0);
                chk("rst_ffv", 32'(first_fail_vec), 0);
                chk("rst_ffvld", 32'(first_fail_vld), 0);
                #2 rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (sample) begin
                if (sb.size() == 0) begin
                    chk("extra_sample", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("stim_order", 32'(stim), 32'(e.stim));
                    chk("sample_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (sb.size() != 0) begin
                chk("stim_hold", 32'(stim), 32'(sb[0].stim));
            end
            if (inject && !sample && busy) begin
                if (stim == 3'd2 && !p2) begin start = 1'b1; p2 = 1; end
                if (stim == 3'd6 && !p6) begin start = 1'b1; p6 = 1; end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;

        chk("done_seen", 32'(done), 1);
        chk("latency", 32'(cyc), 32'(1 + NV * (HOLD + 1)));
        chk("sb_empty", 32'(sb.size()), 0);
        chk("busy_end", 32'(busy), 0);
        chk("fail_cnt", 32'(fail_cnt), 32'(exp_fail));
        chk("ffvld", 32'(first_fail_vld), 32'(exp_vld));
        if (exp_vld) chk("ffv", 32'(first_fail_vec), 32'(exp_ffv));
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", 32'(done), 1);
        chk("stim_kept", 32'(stim), 32'(order(NV - 1)));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stim", 32'(stim), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_sample", 32'(sample), 0);
        chk("reset_fail_cnt", 32'(fail_cnt), 0);
        chk("reset_ffvld", 32'(first_fail_vld), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        mode = 0; run_sweep(0, -1, 0);   // clean sweep
        mode = 1; run_sweep(0, -1, 1);   // stuck-at-0: 4 failures, first at 3
        mode = 0; run_sweep(0, -1, 1);   // restart from DONE with counts cleared
        mode = 1; run_sweep(0, 5, 1);    // reset during vector 5
        mode = 0; run_sweep(0, -1, 0);   // fresh sweep after reset
        mode = 0; run_sweep(1, -1, 1);   // start pulses mid-sweep are ignored

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
